// File: rtl/asynch_tx_pkg.sv
// Shared types for the buffered asynchronous transmitter.
//   states_t      : transmitter FSM states
//   parity_t      : per-frame parity selection
//   decode_parity : maps the 2-bit parity_mode input onto parity_t (3 -> none)
package asynch_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } states_t;

    typedef enum logic [1:0] {
        PAR_NONE = 2'd0,
        PAR_EVEN = 2'd1,
        PAR_ODD  = 2'd2
    } parity_t;

    function automatic parity_t decode_parity(input logic [1:0] mode);
        case (mode)
            2'd1:    return PAR_EVEN;
            2'd2:    return PAR_ODD;
            default: return PAR_NONE;
        endcase
    endfunction

endpackage

// File: rtl/asynch_transmitter_buf_baud_counter.sv
// Bit-period counter for the asynchronous transmitter.
// Counts 0..DIVISOR-1 and wraps; tick marks the last cycle of a bit period.
//   clk   : system clock
//   reset : synchronous, active-low
//   clear : hold the count at 0 (used while the transmitter is idle)
//   tick  : high while the count equals DIVISOR-1
module baud_counter #(
    parameter int DIVISOR = 10417,
    parameter int CW      = $clog2(DIVISOR)
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam logic [CW-1:0] LAST = CW'(DIVISOR - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clear || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/asynch_transmitter_buf.sv
// Buffered asynchronous serial transmitter.
// A one-deep holding register decouples the byte source from the line so
// consecutive frames leave back-to-back. Frame: start, D data bits LSB first,
// optional parity, 1 or 2 stop bits; each bit lasts DIVISOR clocks.
//   clk         : system clock
//   reset       : synchronous, active-low
//   send        : request, accepted when rdy=1
//   data        : frame payload, captured on acceptance
//   parity_mode : 0/3 none, 1 even, 2 odd; captured with data
//   two_stop    : 1 = two stop bits; captured with data
//   txd         : registered serial line, idles high
//   rdy         : holding register empty
//   sending     : a frame is on the line
module asynch_transmitter_buf
    import asynch_tx_pkg::*;
#(
    parameter int D       = 8,
    parameter int DIVISOR = 10417,
    parameter int CW      = $clog2(DIVISOR)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         send,
    input  logic [D-1:0] data,
    input  logic [1:0]   parity_mode,
    input  logic         two_stop,
    output logic         txd,
    output logic         rdy,
    output logic         sending
);

    // Shifter padded to a power of two so the bit index selects it without
    // any out-of-range values.
    localparam int IW = $clog2(D) + 1;
    localparam int SW = 1 << IW;
    localparam logic [IW-1:0] LAST_IDX = IW'(D - 1);

    states_t        state_q;
    logic           hold_valid_q;
    logic [D-1:0]   hold_data_q;
    parity_t        hold_par_q;
    logic           hold_two_q;
    logic [SW-1:0]  shift_q;
    parity_t        par_q;
    logic           two_q;
    logic           stop2_q;     // first of two stop bits already sent
    logic [IW-1:0]  idx_q;
    logic           txd_q;

    logic           tick;
    logic           accept;
    logic           last_stop;
    logic           load;
    logic [IW-1:0]  idx_d;
    logic           par_bit;

    baud_counter #(.DIVISOR(DIVISOR), .CW(CW)) u_baud (
        .clk   (clk),
        .reset (reset),
        .clear (state_q == IDLE),
        .tick  (tick)
    );

    assign rdy       = !hold_valid_q;
    assign sending   = (state_q != IDLE);
    assign txd       = txd_q;
    assign accept    = send && !hold_valid_q;
    assign last_stop = (state_q == STOP) && tick && (!two_q || stop2_q);
    assign load      = hold_valid_q && ((state_q == IDLE) || last_stop);
    assign idx_d     = idx_q + 1'b1;
    assign par_bit   = (par_q == PAR_ODD) ? ~^shift_q : ^shift_q;

    // txd_q is always written with the value belonging to the state being
    // entered, so the line changes on the same edge as the state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            hold_par_q   <= PAR_NONE;
            hold_two_q   <= 1'b0;
            shift_q      <= '0;
            par_q        <= PAR_NONE;
            two_q        <= 1'b0;
            stop2_q      <= 1'b0;
            idx_q        <= '0;
            txd_q        <= 1'b1;
        end else begin
            if (accept) begin
                hold_valid_q <= 1'b1;
                hold_data_q  <= data;
                hold_par_q   <= decode_parity(parity_mode);
                hold_two_q   <= two_stop;
            end else if (load) begin
                hold_valid_q <= 1'b0;
            end

            if (load) begin
                shift_q <= SW'(hold_data_q);
                par_q   <= hold_par_q;
                two_q   <= hold_two_q;
                stop2_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (load) begin
                        state_q <= START;
                        txd_q   <= 1'b0;
                    end else begin
                        txd_q   <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q <= DATA;
                        idx_q   <= '0;
                        txd_q   <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (idx_q == LAST_IDX) begin
                            if (par_q != PAR_NONE) begin
                                state_q <= PARITY;
                                txd_q   <= par_bit;
                            end else begin
                                state_q <= STOP;
                                txd_q   <= 1'b1;
                            end
                        end else begin
                            idx_q <= idx_d;
                            txd_q <= shift_q[idx_d];
                        end
                    end
                end
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        txd_q   <= 1'b1;
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (!last_stop) begin
                            stop2_q <= 1'b1;
                        end else if (load) begin
                            state_q <= START;
                            txd_q   <= 1'b0;
                        end else begin
                            state_q <= IDLE;
                            txd_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    txd_q   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_asynch_transmitter_buf.sv
// Directed bench for asynch_transmitter_buf with D=8, DIVISOR=4.
module tb_asynch_transmitter_buf;

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] data;
    logic [1:0] parity_mode;
    logic       two_stop;
    logic       txd, rdy, sending;

    int cmp = 0;
    int mis = 0;

    asynch_transmitter_buf #(.D(8), .DIVISOR(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .send        (send),
        .data        (data),
        .parity_mode (parity_mode),
        .two_stop    (two_stop),
        .txd         (txd),
        .rdy         (rdy),
        .sending     (sending)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one edge; returns 1 ns after the accept edge.
    task automatic drive_send(input logic [7:0] d, input logic [1:0] pm, input logic ts);
        data        = d;
        parity_mode = pm;
        two_stop    = ts;
        send        = 1'b1;
        step();
        send        = 1'b0;
    endtask

    // Sample n bits of 4 cycles each starting at the next edge. Optional
    // injections of a send at sample ia (data da) and sample ib (data db).
    task automatic expect_bits(input string nm, input logic [15:0] bits, input int n,
                               input int ia, input logic [7:0] da,
                               input int ib, input logic [7:0] db);
        logic bad, sbad, rbad, inj, gotv;
        int k;
        k = 0; inj = 1'b0; sbad = 1'b0; rbad = 1'b0;
        for (int i = 0; i < n; i++) begin
            bad = 1'b0; gotv = bits[i];
            for (int c = 0; c < 4; c++) begin
                step();
                send = 1'b0;
                if (k == 0) begin
                    cmp++;
                    if (rdy !== 1'b1) begin
                        mis++;
                        $display("FAIL %s_rdy_at_load got %b want 1", nm, rdy);
                    end
                end
                if (txd !== bits[i]) begin bad = 1'b1; gotv = txd; end
                if (sending !== 1'b1) sbad = 1'b1;
                if (inj && rdy !== 1'b0) rbad = 1'b1;
                if (k == ia) begin data = da; send = 1'b1; inj = 1'b1; end
                if (k == ib) begin data = db; send = 1'b1; end
                k++;
            end
            cmp++;
            if (bad) begin
                mis++;
                $display("FAIL %s_bit%0d got %b want %b", nm, i, gotv, bits[i]);
            end
        end
        cmp++;
        if (sbad) begin
            mis++;
            $display("FAIL %s_sending got 0 want 1 throughout frame", nm);
        end
        if (ia >= 0) begin
            cmp++;
            if (rbad) begin
                mis++;
                $display("FAIL %s_rdy_held got 1 want 0 while frame held", nm);
            end
        end
    endtask

    task automatic expect_idle(input string nm);
        step();
        cmp++;
        if (sending !== 1'b0 || txd !== 1'b1 || rdy !== 1'b1) begin
            mis++;
            $display("FAIL %s_idle got sending=%b txd=%b rdy=%b want 0 1 1", nm, sending, txd, rdy);
        end
    endtask

    // Right after the accept edge: holding register full, line still idle.
    task automatic expect_accepted(input string nm);
        cmp++;
        if (rdy !== 1'b0 || txd !== 1'b1 || sending !== 1'b0) begin
            mis++;
            $display("FAIL %s_accept got rdy=%b txd=%b sending=%b want 0 1 0", nm, rdy, txd, sending);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; send = 1'b0; data = '0; parity_mode = '0; two_stop = 1'b0;
        repeat (3) step();
        cmp++;
        if (txd !== 1'b1 || rdy !== 1'b1 || sending !== 1'b0) begin
            mis++;
            $display("FAIL reset_state got txd=%b rdy=%b sending=%b want 1 1 0", txd, rdy, sending);
        end
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        drive_send(8'hA5, 2'd0, 1'b0);
        expect_accepted("single");
        expect_bits("single", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00, -1, 8'h00);
        expect_idle("single");
    endtask

    task automatic test_parity();
        // Inputs changed mid-frame must not alter the captured frame.
        drive_send(8'hA5, 2'd1, 1'b0);
        parity_mode = 2'd0; two_stop = 1'b1;
        expect_bits("even", {5'b0, 1'b1, 1'b0, 8'hA5, 1'b0}, 11, -1, 8'h00, -1, 8'h00);
        expect_idle("even");
        drive_send(8'hA5, 2'd2, 1'b0);
        parity_mode = 2'd1;
        expect_bits("odd", {5'b0, 1'b1, 1'b1, 8'hA5, 1'b0}, 11, -1, 8'h00, -1, 8'h00);
        expect_idle("odd");
        drive_send(8'hA5, 2'd3, 1'b0);
        expect_bits("par3", {6'b0, 1'b1, 8'hA5, 1'b0}, 10, -1, 8'h00, -1, 8'h00);
        expect_idle("par3");
    endtask

    task automatic test_two_stop();
        drive_send(8'h3C, 2'd0, 1'b1);
        two_stop = 1'b0;
        expect_bits("two_stop", {5'b0, 2'b11, 8'h3C, 1'b0}, 11, -1, 8'h00, -1, 8'h00);
        expect_idle("two_stop");
    endtask

    task automatic test_back_to_back();
        drive_send(8'h55, 2'd0, 1'b0);
        expect_accepted("b2b");
        // 0F accepted at sample 8; FF offered at sample 20 with rdy=0.
        expect_bits("b2b_f1", {6'b0, 1'b1, 8'h55, 1'b0}, 10, 8, 8'h0F, 20, 8'hFF);
        expect_bits("b2b_f2", {6'b0, 1'b1, 8'h0F, 1'b0}, 10, -1, 8'h00, -1, 8'h00);
        expect_idle("b2b");
    endtask

    task automatic test_reset_mid_frame();
        drive_send(8'hC3, 2'd0, 1'b0);
        repeat (17) step();  // first cycle of data bit 3
        cmp++;
        if (txd !== 1'b0 || sending !== 1'b1) begin
            mis++;
            $display("FAIL midreset_bit3 got txd=%b sending=%b want 0 1", txd, sending);
        end
        reset = 1'b0;
        step();
        cmp++;
        if (txd !== 1'b1 || rdy !== 1'b1 || sending !== 1'b0) begin
            mis++;
            $display("FAIL midreset_abort got txd=%b rdy=%b sending=%b want 1 1 0", txd, rdy, sending);
        end
        reset = 1'b1;
        repeat (2) step();
        cmp++;
        if (txd !== 1'b1 || sending !== 1'b0) begin
            mis++;
            $display("FAIL midreset_no_resume got txd=%b sending=%b want 1 0", txd, sending);
        end
        drive_send(8'h81, 2'd0, 1'b0);
        expect_accepted("after_reset");
        expect_bits("after_reset", {6'b0, 1'b1, 8'h81, 1'b0}, 10, -1, 8'h00, -1, 8'h00);
        expect_idle("after_reset");
    endtask

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_two_stop();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
